// File: rtl/multi_debouncer.sv
// Multi-channel bidirectional debouncer: per-channel synchroniser, stable-time
// filter and registered rise/fall event pulses. One lane instance per channel.

module multi_debouncer_lane #(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_MAX     = 1,
  parameter int   CNT_W       = 1,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic sig_out,
  output logic rise,
  output logic fall
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
    state_d = state_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    // Count only while the synchronised level disagrees; any agreement restarts.
    if (s != state_q) begin
      if (cnt_q < CNT_LAST) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        state_d = s;
        rise_d  = s;
        fall_d  = ~s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      state_q <= RESET_LEVEL;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sig_out = state_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
endmodule

module multi_debouncer #(
  parameter int SYS_CLOCK_FREQ = 50_000_000,
  parameter int NS             = 1000,
  parameter int CHANNELS       = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int RESET_LEVEL    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] sig_in,
  output logic [CHANNELS-1:0] sig_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);
  localparam int SYS_PERIOD_NS = 1_000_000_000 / SYS_CLOCK_FREQ;
  localparam int CNT_RAW       = NS / SYS_PERIOD_NS;
  // Very short stable times still need at least one disagreeing cycle.
  localparam int CNT_MAX       = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam int CNT_W         = $clog2(CNT_MAX + 1);

  multi_debouncer_lane #(
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_MAX     (CNT_MAX),
    .CNT_W       (CNT_W),
    .RESET_LEVEL (1'(RESET_LEVEL))
  ) u_lane [CHANNELS-1:0] (
    .clk     (clk),
    .rst     (rst),
    .sig_in  (sig_in),
    .sig_out (sig_out),
    .rise    (rise),
    .fall    (fall)
  );
endmodule

// File: doc/multi_debouncer.md
# multi_debouncer

Multi-channel, bidirectional switch/button debouncer. Each channel synchronises an asynchronous input, then accepts a new level only after it has been stable for a programmable time. The filtered level is registered and paired with one-cycle rise/fall event pulses. It sits between board-level inputs and the PWM control logic, and supersedes the single-channel, assert-only debouncer: release is filtered too, inputs are synchronised, and the reset level is configurable.

## Interface

**Parameters**
- `SYS_CLOCK_FREQ`, default 50_000_000: clock frequency in Hz.
- `NS`, default 1000: required stable time in ns.
- `CHANNELS`, default 4: number of independent channels (≥1).
- `SYNC_STAGES`, default 2: synchroniser flops per channel (≥2).
- `RESET_LEVEL`, default 0: filtered level, and synchroniser contents, loaded on reset (0 or 1, applied to all channels).

**Derived localparams**
- `SYS_PERIOD_NS` = 10**9 / SYS_CLOCK_FREQ (integer division).
- `CNT_MAX` = NS / SYS_PERIOD_NS, clamped to a minimum of 1.
- Counter width = $clog2(CNT_MAX+1).

**Ports**
- `clk` input 1: system clock, rising edge.
- `rst` input 1: reset. Synchronous and active-high.
- `sig_in` input CHANNELS: raw asynchronous inputs, one bit per channel.
- `sig_out` output CHANNELS: debounced level, registered.
- `rise` output CHANNELS: one-cycle pulse when `sig_out[i]` goes 0→1.
- `fall` output CHANNELS: one-cycle pulse when `sig_out[i]` goes 1→0.

## Operation

- Channels are fully independent. Same logic per channel `i`. No shared state.
- **Synchroniser:** an SYNC_STAGES-deep shift register. `s[i]` is the last stage.
- **Per-channel registers:**
  - `state[i]`, which drives `sig_out[i]`.
  - Counter `cnt[i]`.
  - Pulse flops `rise[i]` and `fall[i]`.
- **Each cycle, not in reset:**
  - If `s[i] == state[i]`: `cnt[i]` <= 0. No event.
  - Else if `cnt[i] < CNT_MAX-1`: `cnt[i]` <= `cnt[i]+1`. No event.
  - Else (`s[i] != state[i]` and `cnt[i] == CNT_MAX-1`):
    - `state[i]` <= `s[i]` and `cnt[i]` <= 0.
    - `rise[i]` <= `s[i]` and `fall[i]` <= `~s[i]`.
  - `rise[i]` and `fall[i]` are 0 in every cycle with no event.
- **Acceptance rule:** a new level is accepted after exactly CNT_MAX consecutive cycles in which `s[i] != state[i]`. Any cycle where `s[i] == state[i]` restarts the count from 0.
- `rise[i]` and `fall[i]` are never high together.
- The counter never exceeds CNT_MAX-1. There is no wrap-around.

## Timing

- **Reset**, while `rst` is sampled high at a rising edge:
  - All synchroniser flops <= RESET_LEVEL.
  - `state` <= RESET_LEVEL, so `sig_out` = {CHANNELS{RESET_LEVEL}}.
  - `cnt` <= 0.
  - `rise` = `fall` = 0.
- Reset asserted mid-count discards the count. No event is produced.
- Leaving reset never generates an event by itself. An input held at ~RESET_LEVEL is accepted normally, with the full latency below.
- **Latency:** number the first rising edge that samples a new stable `sig_in` level as edge 1. `sig_out[i]` and the matching pulse update at edge SYNC_STAGES + CNT_MAX.
  - Defaults (CNT_MAX = 50, SYNC_STAGES = 2): edge 52.
- Pulses are high for exactly one clock, aligned with the `sig_out` change.
- **Glitch rejection:** a level lasting fewer than CNT_MAX cycles after synchronisation produces no output change.
- **Simultaneous events:** events on different channels in the same cycle are independent. Each channel asserts its own pulse.
- All outputs come straight from flops. There is no combinational path from `sig_in` to any output.

## Test plan

All scenarios use SYS_CLOCK_FREQ = 100_000_000, NS = 50 (CNT_MAX = 5), CHANNELS = 4, SYNC_STAGES = 2, RESET_LEVEL = 0 unless stated.

1. **Reset values:** hold `rst` 3 cycles with `sig_in` = 4'b1111 → during reset `sig_out` = 0, `rise` = `fall` = 0. After release, `sig_out` = 4'b1111 at edge 7 counted from the first post-reset edge. `rise` = 4'b1111 for that one cycle only.
2. **Press and release:** `sig_in[0]` 0→1, held 20 cycles → `sig_out[0]` = 1 and `rise[0]` pulse at edge 7. Then 1→0 → `sig_out[0]` = 0 and `fall[0]` pulse 7 edges later. Other channels remain 0.
3. **Glitch rejection:**
   - `sig_in[1]` high for 4 cycles → `sig_out[1]` stays 0 and no pulses.
   - High for exactly 5 cycles → `sig_out[1]` = 1 once.
   - Bounce 1,1,1,0,1,1,1,1,1 → acceptance 5 cycles after the last 0.
4. **Simultaneous channels:** `sig_in` 0000→1010 on one edge, later 1010→0101 → `rise` = 1010 at edge 7. On the second change, `fall` = 1010 and `rise` = 0101 in the same cycle. `rise & fall` is 0 in every cycle.
5. **Reset mid-count:** start a 0→1 change on ch2, assert `rst` at count 3 for 1 cycle with input held high → no pulse before reset. After reset, full 7-edge latency, then one `rise[2]`.
6. **Parameter corners:**
   - RESET_LEVEL = 1 with inputs high through reset → no events.
   - NS = 5 (CNT_MAX clamped to 1) → acceptance at edge SYNC_STAGES+1 = 3.
   - SYNC_STAGES = 3 → latency 8.
